// File: rtl/if_id_queue_pkg.sv
// Shared fetch-packet definitions for IF, the IF/ID queue and ID_EX0.
//   PC_W / INST_W : fetch packet field widths
//   fetch_pkt_t   : {pc, inst, pred_taken} as carried from fetch to decode
//   INST_NOP      : instruction encoding that decode treats as a bubble
package if_id_queue_pkg;
  localparam int PC_W   = 32;
  localparam int INST_W = 32;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              pred_taken;
  } fetch_pkt_t;

  localparam int PKT_W = $bits(fetch_pkt_t);

  localparam logic [INST_W-1:0] INST_NOP   = '0;
  localparam fetch_pkt_t        PKT_BUBBLE = '{pc: '0, inst: INST_NOP, pred_taken: 1'b0};
endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-to-decode handshake bundle.
//   in_*  : IF side, valid/ready plus the fetched packet
//   out_* : ID side, valid/ready plus the head packet
// slave  : the queue
// master : the environment (IF producer + ID consumer)
interface if_id_queue_if;
  import if_id_queue_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [INST_W-1:0] in_inst;
  logic              in_pred_taken;

  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;
  logic              out_pred_taken;

  modport slave (
    input  in_valid, in_pc, in_inst, in_pred_taken, out_ready,
    output in_ready, out_valid, out_pc, out_inst, out_pred_taken
  );

  modport master (
    output in_valid, in_pc, in_inst, in_pred_taken, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, out_pred_taken
  );
endinterface

// File: rtl/if_id_queue_sync_fifo_fwft.sv
// Generic first-word-fall-through circular buffer with synchronous flush.
//   clk, rst        : clock, synchronous active-high reset
//   flush           : drop all contents next cycle; same-cycle wr/rd ignored
//   wr_en, wr_data  : write request (accepted only when not full)
//   rd_en           : pop request (accepted only when not empty)
//   rd_data         : head entry, read combinationally from mem[rd_ptr]
//   full, empty     : derived from registered occupancy only
//   cnt             : occupancy, 0..DEPTH
module sync_fifo_fwft #(
  parameter int DEPTH  = 4,
  parameter int WIDTH  = 65,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   cnt
);
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_fire;
  logic              rd_fire;

  assign full    = (cnt == (ADDR_W+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // DEPTH is a power of two, so pointer wrap is plain ADDR_W-bit overflow.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_fire, rd_fire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_fire && !flush && !rst) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/if_id_queue.sv
// IF->ID instruction queue (FWFT). Decouples fetch from back-end stalls.
//   clk, rst                   : clock, synchronous active-high reset
//   IF_ID_stall_from_DCache    : blocks dequeue; head held stable
//   IF_ID_flush_from_EX_Branch : discards all entries and the same-cycle fetch
//   bus (slave)                : in_* from IF, out_* to ID
//   count                      : occupancy for debug/perf counters
// in_ready depends only on registered occupancy; out_* are forced to a
// bubble (all zero) while empty so ID sees inst=0.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            IF_ID_stall_from_DCache,
  input  logic            IF_ID_flush_from_EX_Branch,
  if_id_queue_if.slave    bus,
  output logic [ADDR_W:0] count
);
  fetch_pkt_t wr_pkt;
  fetch_pkt_t head_pkt;
  logic       full;
  logic       empty;
  logic       enq;
  logic       deq;

  assign wr_pkt = '{pc: bus.in_pc, inst: bus.in_inst, pred_taken: bus.in_pred_taken};

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign enq = bus.in_valid && bus.in_ready;
  assign deq = bus.out_valid && bus.out_ready && !IF_ID_stall_from_DCache;

  sync_fifo_fwft #(
    .DEPTH  (DEPTH),
    .WIDTH  (PKT_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (IF_ID_flush_from_EX_Branch),
    .wr_en   (enq),
    .wr_data (wr_pkt),
    .rd_en   (deq),
    .rd_data (head_pkt),
    .full    (full),
    .empty   (empty),
    .cnt     (count)
  );

  always_comb begin
    bus.out_pc         = PKT_BUBBLE.pc;
    bus.out_inst       = PKT_BUBBLE.inst;
    bus.out_pred_taken = PKT_BUBBLE.pred_taken;
    if (!empty) begin
      bus.out_pc         = head_pkt.pc;
      bus.out_inst       = head_pkt.inst;
      bus.out_pred_taken = head_pkt.pred_taken;
    end
  end
endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (DEPTH=4).
module tb_if_id_queue;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            stall = 1'b0;
  logic            flush = 1'b0;
  logic [ADDR_W:0] count;
  logic            started = 1'b0;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  if_id_queue_if bus();

  if_id_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .IF_ID_stall_from_DCache    (stall),
    .IF_ID_flush_from_EX_Branch (flush),
    .bus                        (bus),
    .count                      (count)
  );

  always #5 clk = ~clk;

  // Pointer/occupancy invariant.
  logic [ADDR_W-1:0] ptr_diff;
  always @(negedge clk) begin
    ptr_diff = dut.u_fifo.wr_ptr - dut.u_fifo.rd_ptr;
    if (started && !rst) begin
      assert (ptr_diff == dut.u_fifo.cnt[ADDR_W-1:0]);
      assert (dut.u_fifo.cnt <= (ADDR_W+1)'(DEPTH));
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], 16'h0013};
  endfunction

  task automatic drive(input logic [31:0] pc);
    bus.in_pc         = pc;
    bus.in_inst       = inst_of(pc);
    bus.in_pred_taken = pc[2];
  endtask

  task automatic enq1(input logic [31:0] pc);
    drive(pc);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain1(input string tag, input logic [31:0] pc);
    chk({tag, ".vld"},  32'(bus.out_valid), 32'd1);
    chk({tag, ".pc"},   bus.out_pc, pc);
    chk({tag, ".inst"}, bus.out_inst, inst_of(pc));
    chk({tag, ".pred"}, 32'(bus.out_pred_taken), 32'(pc[2]));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    drive(32'h0);

    // reset then idle
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    started = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle.vld",  32'(bus.out_valid), 32'd0);
      chk("idle.rdy",  32'(bus.in_ready), 32'd1);
      chk("idle.cnt",  32'(count), 32'd0);
      chk("idle.inst", bus.out_inst, 32'd0);
    end

    // three enqueues without consumer, then drain in order
    for (int i = 0; i < 3; i++) begin
      enq1(32'h1c000000 + 32'(4*i));
      chk("fill3.cnt", 32'(count), 32'(i+1));
    end
    for (int i = 0; i < 3; i++) drain1("drain3", 32'h1c000000 + 32'(4*i));
    chk("drain3.cnt", 32'(count), 32'd0);
    chk("drain3.vld", 32'(bus.out_valid), 32'd0);
    chk("drain3.pc0", bus.out_pc, 32'd0);

    // fill to full across the pointer wrap, back-pressure, then refill
    for (int i = 0; i < 4; i++) enq1(32'h1c000040 + 32'(4*i));
    chk("full.cnt", 32'(count), 32'd4);
    chk("full.rdy", 32'(bus.in_ready), 32'd0);
    drive(32'h1c000010);
    bus.in_valid = 1'b1;
    tick();
    chk("full.hold.cnt", 32'(count), 32'd4);
    chk("full.hold.pc",  bus.out_pc, 32'h1c000040);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("deq1.cnt", 32'(count), 32'd3);
    chk("deq1.rdy", 32'(bus.in_ready), 32'd1);
    chk("deq1.pc",  bus.out_pc, 32'h1c000044);
    tick();
    bus.in_valid = 1'b0;
    chk("refill.cnt", 32'(count), 32'd4);
    drain1("wrap", 32'h1c000044);
    drain1("wrap", 32'h1c000048);
    drain1("wrap", 32'h1c00004c);
    drain1("wrap", 32'h1c000010);
    chk("wrap.cnt", 32'(count), 32'd0);

    // stall: enqueue continues, head stays put
    enq1(32'h1c000080);
    enq1(32'h1c000084);
    stall = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(32'h1c000088 + 32'(4*i));
      tick();
      chk("stall.pc",   bus.out_pc, 32'h1c000080);
      chk("stall.inst", bus.out_inst, inst_of(32'h1c000080));
      chk("stall.cnt",  32'(count), (i == 0) ? 32'd3 : 32'd4);
    end
    stall = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    drain1("stall.drain", 32'h1c000080);
    drain1("stall.drain", 32'h1c000084);
    drain1("stall.drain", 32'h1c000088);
    drain1("stall.drain", 32'h1c00008c);
    chk("stall.end.cnt", 32'(count), 32'd0);

    // flush with simultaneous enq/deq attempt
    enq1(32'h1c0000c0);
    enq1(32'h1c0000c4);
    enq1(32'h1c0000c8);
    chk("preflush.cnt", 32'(count), 32'd3);
    drive(32'h1c0000cc);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.out_ready = 1'b0;
    chk("flush.cnt", 32'(count), 32'd0);
    chk("flush.vld", 32'(bus.out_valid), 32'd0);
    chk("flush.pc",  bus.out_pc, 32'd0);
    drive(32'h1c000100);
    tick();
    bus.in_valid = 1'b0;
    chk("postflush.cnt", 32'(count), 32'd1);
    drain1("postflush", 32'h1c000100);

    // steady enq+deq at count 2, then reset mid-stream
    enq1(32'h1c000200);
    enq1(32'h1c000204);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("stream.pc", bus.out_pc, 32'h1c000200 + 32'(4*i));
      drive(32'h1c000208 + 32'(4*i));
      tick();
      chk("stream.cnt", 32'(count), 32'd2);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst.cnt", 32'(count), 32'd0);
    chk("midrst.vld", 32'(bus.out_valid), 32'd0);
    chk("midrst.rdy", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    chk("postrst.cnt", 32'(count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- First-word-fall-through instruction queue between the fetch stage (IF) and decode (ID).
- Decouples fetch from back-end stalls: ID consumes from the queue head while IF keeps filling it.
- Honours the same stall and flush controls that ID_EX0 receives: DCache stall and EX branch flush.
- Decoded output of ID feeds ID_EX0 directly.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
ADDR_W, 2, pointer width = log2(DEPTH)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
IF_ID_stall_from_DCache  input  1  back-end stall; blocks dequeue
IF_ID_flush_from_EX_Branch  input  1  branch mispredict; discards all contents
in_valid  input  1  IF presents an instruction
in_ready  output  1  queue can accept (count < DEPTH)
in_pc  input  32  fetch PC
in_inst  input  32  instruction word
in_pred_taken  input  1  BPU prediction bit
out_valid  output  1  head entry valid (count != 0)
out_ready  input  1  ID accepts head
out_pc  output  32  head PC
out_inst  output  32  head instruction
out_pred_taken  output  1  head prediction bit
count  output  ADDR_W+1  occupancy, for debug/perf counters

Behaviour:
- Storage: DEPTH-entry circular buffer of {pc, inst, pred_taken}; wr_ptr, rd_ptr (ADDR_W bits), cnt (ADDR_W+1 bits). Pointers wrap modulo DEPTH naturally.
- Handshakes:
  - enq = in_valid && in_ready.
  - deq = out_valid && out_ready && !IF_ID_stall_from_DCache.
- in_ready = (cnt != DEPTH). Purely a function of registered cnt; no combinational path from out_ready or stall.
- out_valid = (cnt != 0). Head data is read combinationally from mem[rd_ptr]. When cnt == 0, out_pc/out_inst/out_pred_taken are forced to 0; out_inst=0 decodes as a bubble in ID.
- Latency: an instruction enqueued in cycle N is visible on out_* in cycle N+1. No empty-bypass.
- Per-cycle update (no flush):
  - enq writes mem[wr_ptr] and wr_ptr+1.
  - deq advances rd_ptr+1.
  - cnt += enq - deq.
- Simultaneous enq and deq:
  - Allowed whenever 0 < cnt < DEPTH; cnt unchanged.
  - When full: in_ready=0, so deq only.
  - When empty: out_valid=0, so enq only.
- Flush (IF_ID_flush_from_EX_Branch=1):
  - Next cycle: wr_ptr=rd_ptr=0, cnt=0.
  - Any same-cycle enq or deq is ignored, i.e. the flushing-cycle fetch is dropped.
  - Flush has priority over stall. Memory contents need not be cleared.
- Stall (IF_ID_stall_from_DCache=1, no flush):
  - deq suppressed; head stays stable, out_* must not change.
  - enq continues until full.
- Reset (rst=1 at posedge): wr_ptr=rd_ptr=cnt=0.
  - Outputs after reset: out_valid=0, out_* =0, in_ready=1, count=0.
  - Reset mid-operation discards all entries identically to flush.
  - Reset has priority over flush.
- Invariant: cnt never exceeds DEPTH and never underflows. An assertion in the bench checks wr_ptr - rd_ptr ≡ cnt mod DEPTH.

Decomposition:
- Shared package: fetch packet width constants (PC_W=32, INST_W=32), packet typedef {pc, inst, pred_taken}, and the NOP/bubble encoding constant. These are reused by ID_EX0 and IF.
- One natural sub-module: sync_fifo_fwft. It is a generic DEPTH×WIDTH circular buffer with flush input. if_id_queue wraps it and adds stall gating and zero-forcing of the outputs when empty.

Test Plan:
- Reset then idle → out_valid=0, in_ready=1, count=0, out_inst=0 for 5 cycles.
- Enqueue pc 0x1c000000, 0x1c000004, 0x1c000008 with out_ready=0 → count 1,2,3.
  - Then out_ready=1 → head pc 0x1c000000, 0x1c000004, 0x1c000008 in consecutive cycles.
  - Count drops to 0; out_valid=0 after.
- Fill 4 entries → in_ready=0; in_valid held with pc 0x1c000010 is not accepted. Dequeue one → in_ready=1 next cycle; 0x1c000010 lands as 4th entry after wrap.
- Count=2 with IF_ID_stall_from_DCache=1 and out_ready=1 for 3 cycles, in_valid=1 → no dequeue, head pc unchanged, count reaches 4 and holds.
- Count=3 with in_valid=1 and flush=1 in the same cycle → next cycle count=0, out_valid=0. Following enqueue of 0x1c000100 appears as head one cycle later.
- Continuous enq+deq at count=2 for 10 cycles → count stays 2, output order matches input order. rst asserted mid-stream → count=0 next cycle.
